// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer, datapath muxes and
// immediate extender.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_U = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_S = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10,
    SRC_A_ZERO  = 2'b11
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } result_src_e;

  typedef struct packed {
    logic      legal;
    alu_ctrl_e op;
  } alu_dec_t;

  // sub_sel is funct7[5] for register ops and forced low for immediate ops.
  function automatic alu_dec_t decode_alu(input logic [2:0] funct3, input logic sub_sel);
    alu_dec_t d;
    d.legal = 1'b1;
    d.op    = ALU_ADD;
    case (funct3)
      3'b000:  d.op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  d.op = ALU_AND;
      3'b110:  d.op = ALU_OR;
      3'b100:  d.op = ALU_XOR;
      3'b010:  d.op = ALU_SLT;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback control.
// Define MC_PERF_CNT_EN to build the instret and stall_cyc counters.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   instr,
  input  logic              zero,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              adr_src,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [3:0]        alu_ctrl,
  output logic [1:0]        result_src,
  output logic [2:0]        imm_src,
  output logic              illegal,
  output logic [PERF_W-1:0] instret,
  output logic [PERF_W-1:0] stall_cyc
);

  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  alu_dec_t   alu_r, alu_i;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_b5    = instr[30];
  assign alu_r        = decode_alu(funct3, funct7_b5);
  assign alu_i        = decode_alu(funct3, 1'b0);
  assign unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

`ifdef MC_PERF_CNT_EN
  logic [PERF_W-1:0] instret_q, instret_d, stall_cyc_q, stall_cyc_d;
  assign instret   = instret_q;
  assign stall_cyc = stall_cyc_q;
`else
  assign instret   = '0;
  assign stall_cyc = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
`ifdef MC_PERF_CNT_EN
      instret_q   <= '0;
      stall_cyc_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
`ifdef MC_PERF_CNT_EN
      instret_q   <= instret_d;
      stall_cyc_q <= stall_cyc_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    illegal    = 1'b0;
`ifdef MC_PERF_CNT_EN
    instret_d   = instret_q;
    stall_cyc_d = stall_cyc_q;
`endif

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      // The branch/jump target is precomputed here into ALUOut.
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_OP:             state_d = S_EXEC_R;
          OP_OPIMM:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ack) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ack) state_d = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        if (alu_r.legal) begin
          alu_ctrl = alu_r.op;
          state_d  = S_ALUWB;
        end else begin
          state_d  = S_TRAP;
        end
      end

      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_I;
        if (alu_i.legal) begin
          alu_ctrl = alu_i.op;
          state_d  = S_ALUWB;
        end else begin
          state_d  = S_TRAP;
        end
      end

      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_ctrl   = ALU_SUB;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000: begin
            pc_write = zero;
            state_d  = S_FETCH;
          end
          3'b001: begin
            pc_write = !zero;
            state_d  = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end

      // PC takes the target from ALUOut while the ALU forms the link value.
      S_JAL: begin
        pc_write   = 1'b1;
        result_src = RES_ALUOUT;
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        state_d    = S_ALUWB;
      end

      S_LUI: begin
        imm_src   = IMM_U;
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ALUWB;
      end

      S_TRAP: illegal = 1'b1;

      default: state_d = S_IDLE;
    endcase

`ifdef MC_PERF_CNT_EN
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
      instret_d = instret_q + PERF_W'(1);
    if (mem_req && !mem_ack)
      stall_cyc_d = stall_cyc_q + PERF_W'(1);
`endif
  end

endmodule
